keyscan_window: RTL and testbench
=================================

# keyscan_window

- Parametrised successor of the single-bit key scanner.
- Holds an N-bit scalar and serves it MSB-first as W-bit window digits to the point-multiplication controller.
- Provides leading-one search, zero/one key classification and a two-level checkpoint (temporary and committed) for fault recovery.
- Optional parity protection on the checkpoint registers flags corrupted backups.

## Interface
- N, 233: key width in bits.
- W, 1: digit width in bits, legal 1..4.
- CW, 8: counter width; must satisfy 2^CW > N+W.
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- key_in  in  N  scalar, sampled on accepted load.
- load  in  1  load request.
- find_req  in  1  leading-one search request.
- step_req  in  1  next-digit request.
- op_code  in  2  checkpoint operation: 00 none, 01 save key/cnt to tmp, 10 commit tmp to backup, 11 restore backup to working.
- busy  out  1  high while in CLASSIFY or FIND; all requests are ignored while high.
- digit  out  W  emitted digit, MSB of the window in bit W-1.
- digit_valid  out  1  one-cycle pulse qualifying digit.
- first_found  out  1  leading one located; sticky until load.
- last  out  1  high when key_cnt == N (key exhausted).
- key_cnt  out  CW  bits consumed so far.
- key_state  out  2  00 normal, 01 key is zero, 11 key is one.
- fault  out  1  checkpoint parity error, sticky; constant 0 without the macro.

## Operation
- States:
  - IDLE
  - CLASSIFY (1 cycle)
  - FIND (1 bit per cycle)
- Request priority in IDLE, one action per cycle: load > op_code != 00 > find_req > step_req.
- Load:
  - key <= key_in; key_cnt <= 0.
  - Backup key <= key_in; backup cnt <= 0. Tmp checkpoint is unchanged.
  - first_found, digit, last <= 0; fault <= 0.
  - Next state CLASSIFY.
- CLASSIFY: key_state <= 01 if key == 0, 11 if key == 1, else 00. Then IDLE.
- FIND, each cycle:
  - key <<= 1; key_cnt += 1.
  - If the old key[N-1] == 1: first_found <= 1; digit <= 1 (zero-extended); digit_valid pulse; go to IDLE.
  - If key_cnt reaches N with no one found: go to IDLE with last = 1, first_found = 0, no digit_valid.
- Step (IDLE, last = 0):
  - digit <= key[N-1 -: W].
  - key <<= W, zero-filling from the LSB.
  - key_cnt <= min(key_cnt + W, N).
  - digit_valid pulse.
  - When N mod W != 0, the final digit carries zero padding in its low bits.
- Step with last = 1: ignored; no pulse; outputs hold.
- Restore (op 11): key and key_cnt take backup values; last is recomputed from the restored count; first_found is unchanged.
- Save (01) and commit (10) do not affect key, key_cnt or outputs.
- key_state changes only in CLASSIFY or on reset.

## Timing
- Reset values:
  - All outputs 0; state IDLE.
  - key, backup and tmp registers 0.
- The reset is asynchronous: asserting RST mid-FIND aborts the search immediately. No pulse is emitted after reset.
- Load accepted at edge t: busy = 1 during cycle t..t+1; key_state is valid and busy = 0 after edge t+1.
- Step accepted at edge t: digit, digit_valid, key_cnt and last are updated at edge t (registered), so the step has 1-cycle latency and back-to-back steps give one digit per cycle.
- Find from key_cnt = c with the leading one at bit position p (counted from MSB): busy for p+1 cycles, with a single digit_valid on the final edge.
- Checkpoint operations take effect at the accepting edge.
- Saving the state after a step captures the post-step values.

## Configuration
- KEYSCAN_WIN_PARITY_EN defined:
  - Tmp and backup checkpoints each store an even-parity bit over {key, cnt}.
  - Commit copies the parity bit; restore recomputes it.
  - On mismatch: restore is aborted (working registers unchanged) and fault <= 1.
  - fault clears only on load or RST.
- KEYSCAN_WIN_PARITY_EN undefined: no parity storage; fault is tied 0; restore is unconditional.

## Test plan
- N=8, W=1, load 8'h25, find -> 3 busy cycles, digit = 1, key_cnt = 3; then 5 steps give 0,0,1,0,1 and last = 1 after the 5th.
- N=8, W=3, load 8'hB6, 3 steps -> digits 101, 101, 100 (padded); key_cnt 3, 6, 8; 4th step gives no digit_valid.
- Load 0 -> key_state = 01; load 1 -> key_state = 11; find on zero key -> 8 cycles, last = 1, first_found = 0.
- Load 8'hF0, W=1:
  - step twice, op 01, op 10, step 3 times, op 11 -> key_cnt = 2; next step digit = 1.
- Assert RST mid-FIND -> busy and all outputs 0 at once, with no digit_valid.
- PARITY_EN: save, commit, force a bit flip in the backup key, then op 11 -> fault = 1, key_cnt unchanged; a new load clears fault.

Source files
------------

// File: rtl/keyscan_window.sv
// rtl/keyscan_window.sv - N-bit scalar served MSB-first as W-bit digits, with leading-one search and two-level checkpoint
// Optional feature macro: KEYSCAN_WIN_PARITY_EN (even parity on tmp/backup checkpoints, sticky fault flag).
module keyscan_window #(
  parameter int N  = 233,
  parameter int W  = 1,
  parameter int CW = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [N-1:0]  key_in,
  input  logic          load,
  input  logic          find_req,
  input  logic          step_req,
  input  logic [1:0]    op_code,
  output logic          busy,
  output logic [W-1:0]  digit,
  output logic          digit_valid,
  output logic          first_found,
  output logic          last,
  output logic [CW-1:0] key_cnt,
  output logic [1:0]    key_state,
  output logic          fault
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_CLASSIFY = 2'b01,
    S_FIND     = 2'b10
  } state_t;

  localparam logic [CW-1:0] N_CNT      = CW'(N);
  localparam logic [CW-1:0] W_CNT      = CW'(W);
  localparam logic [CW-1:0] ONE_CNT    = CW'(1);
  localparam logic [N-1:0]  KEY_ONE    = N'(1);
  localparam logic [1:0]    OP_NONE    = 2'b00;
  localparam logic [1:0]    OP_SAVE    = 2'b01;
  localparam logic [1:0]    OP_COMMIT  = 2'b10;

  state_t        state_q, state_d;
  logic [N-1:0]  key_q, key_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  tmp_key_q, tmp_key_d;
  logic [CW-1:0] tmp_cnt_q, tmp_cnt_d;
  logic [N-1:0]  bak_key_q, bak_key_d;
  logic [CW-1:0] bak_cnt_q, bak_cnt_d;
  logic [W-1:0]  digit_q, digit_d;
  logic          digit_valid_q, digit_valid_d;
  logic          first_found_q, first_found_d;
  logic          last_q, last_d;
  logic [1:0]    key_state_q, key_state_d;
  logic [CW-1:0] step_sum;
  logic [CW-1:0] cnt_inc;
  logic          restore_ok;

`ifdef KEYSCAN_WIN_PARITY_EN
  logic tmp_par_q, tmp_par_d;
  logic bak_par_q, bak_par_d;
  logic fault_q, fault_d;

  // A backup is trusted only when its stored parity matches a fresh recomputation.
  assign restore_ok = ((^{bak_key_q, bak_cnt_q}) == bak_par_q);

  // Parity bits follow the checkpoint they guard; a failed restore raises the sticky fault.
  always_comb begin
    tmp_par_d = tmp_par_q;
    bak_par_d = bak_par_q;
    fault_d   = fault_q;
    if (state_q == S_IDLE) begin
      if (load) begin
        bak_par_d = ^{key_in, {CW{1'b0}}};
        fault_d   = 1'b0;
      end else if (op_code == OP_SAVE) begin
        tmp_par_d = ^{key_q, cnt_q};
      end else if (op_code == OP_COMMIT) begin
        bak_par_d = tmp_par_q;
      end else if (op_code != OP_NONE && !restore_ok) begin
        fault_d   = 1'b1;
      end
    end
  end

  // Parity and fault registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tmp_par_q <= 1'b0;
      bak_par_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      tmp_par_q <= tmp_par_d;
      bak_par_q <= bak_par_d;
      fault_q   <= fault_d;
    end
  end

  assign fault = fault_q;
`else
  assign restore_ok = 1'b1;
  assign fault      = 1'b0;
`endif

  assign step_sum = cnt_q + W_CNT;
  assign cnt_inc  = cnt_q + ONE_CNT;

  // Next-state and next-output logic: one accepted action per IDLE cycle, fixed priority.
  always_comb begin
    state_d       = state_q;
    key_d         = key_q;
    cnt_d         = cnt_q;
    tmp_key_d     = tmp_key_q;
    tmp_cnt_d     = tmp_cnt_q;
    bak_key_d     = bak_key_q;
    bak_cnt_d     = bak_cnt_q;
    digit_d       = digit_q;
    digit_valid_d = 1'b0;
    first_found_d = first_found_q;
    last_d        = last_q;
    key_state_d   = key_state_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          key_d         = key_in;
          cnt_d         = '0;
          bak_key_d     = key_in;
          bak_cnt_d     = '0;
          first_found_d = 1'b0;
          digit_d       = '0;
          last_d        = 1'b0;
          state_d       = S_CLASSIFY;
        end else if (op_code != OP_NONE) begin
          if (op_code == OP_SAVE) begin
            tmp_key_d = key_q;
            tmp_cnt_d = cnt_q;
          end else if (op_code == OP_COMMIT) begin
            bak_key_d = tmp_key_q;
            bak_cnt_d = tmp_cnt_q;
          end else if (restore_ok) begin
            key_d  = bak_key_q;
            cnt_d  = bak_cnt_q;
            last_d = (bak_cnt_q == N_CNT);
          end
        end else if (find_req) begin
          state_d = S_FIND;
        end else if (step_req && !last_q) begin
          digit_d       = key_q[N-1 -: W];
          key_d         = key_q << W;
          cnt_d         = (step_sum >= N_CNT) ? N_CNT : step_sum;
          last_d        = (step_sum >= N_CNT);
          digit_valid_d = 1'b1;
        end
      end
      S_CLASSIFY: begin
        if (key_q == '0) begin
          key_state_d = 2'b01;
        end else if (key_q == KEY_ONE) begin
          key_state_d = 2'b11;
        end else begin
          key_state_d = 2'b00;
        end
        state_d = S_IDLE;
      end
      S_FIND: begin
        if (cnt_q >= N_CNT) begin
          // Nothing left to scan: report exhaustion without shifting.
          last_d        = 1'b1;
          first_found_d = 1'b0;
          state_d       = S_IDLE;
        end else begin
          key_d = key_q << 1;
          cnt_d = cnt_inc;
          if (key_q[N-1]) begin
            first_found_d = 1'b1;
            digit_d       = W'(1);
            digit_valid_d = 1'b1;
            last_d        = (cnt_inc == N_CNT);
            state_d       = S_IDLE;
          end else if (cnt_inc == N_CNT) begin
            last_d        = 1'b1;
            first_found_d = 1'b0;
            state_d       = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, working key, checkpoints and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= S_IDLE;
      key_q         <= '0;
      cnt_q         <= '0;
      tmp_key_q     <= '0;
      tmp_cnt_q     <= '0;
      bak_key_q     <= '0;
      bak_cnt_q     <= '0;
      digit_q       <= '0;
      digit_valid_q <= 1'b0;
      first_found_q <= 1'b0;
      last_q        <= 1'b0;
      key_state_q   <= 2'b00;
    end else begin
      state_q       <= state_d;
      key_q         <= key_d;
      cnt_q         <= cnt_d;
      tmp_key_q     <= tmp_key_d;
      tmp_cnt_q     <= tmp_cnt_d;
      bak_key_q     <= bak_key_d;
      bak_cnt_q     <= bak_cnt_d;
      digit_q       <= digit_d;
      digit_valid_q <= digit_valid_d;
      first_found_q <= first_found_d;
      last_q        <= last_d;
      key_state_q   <= key_state_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign digit       = digit_q;
  assign digit_valid = digit_valid_q;
  assign first_found = first_found_q;
  assign last        = last_q;
  assign key_cnt     = cnt_q;
  assign key_state   = key_state_q;

endmodule

// File: tb/tb_keyscan_window.sv
// tb/tb_keyscan_window.sv - self-checking bench for keyscan_window (N=8, W=1 and W=3 instances)
module tb_keyscan_window;
  localparam int N  = 8;
  localparam int CW = 8;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  logic [N-1:0]  key_in = '0;
  logic          load = 1'b0, find_req = 1'b0, step_req = 1'b0;
  logic [1:0]    op_code = 2'b00;
  logic          busy, digit_valid, first_found, last, fault;
  logic [0:0]    digit;
  logic [CW-1:0] key_cnt;
  logic [1:0]    key_state;

  logic [N-1:0]  key_in3 = '0;
  logic          load3 = 1'b0, find3 = 1'b0, step3 = 1'b0;
  logic [1:0]    op3 = 2'b00;
  logic          busy3, dv3, ff3, last3, fault3;
  logic [2:0]    digit3;
  logic [CW-1:0] cnt3;
  logic [1:0]    ks3;

  keyscan_window #(.N(N), .W(1), .CW(CW)) dut (
    .CLK(CLK), .RST(RST), .key_in(key_in), .load(load), .find_req(find_req),
    .step_req(step_req), .op_code(op_code), .busy(busy), .digit(digit),
    .digit_valid(digit_valid), .first_found(first_found), .last(last),
    .key_cnt(key_cnt), .key_state(key_state), .fault(fault)
  );

  keyscan_window #(.N(N), .W(3), .CW(CW)) dut3 (
    .CLK(CLK), .RST(RST), .key_in(key_in3), .load(load3), .find_req(find3),
    .step_req(step3), .op_code(op3), .busy(busy3), .digit(digit3),
    .digit_valid(dv3), .first_found(ff3), .last(last3),
    .key_cnt(cnt3), .key_state(ks3), .fault(fault3)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Reference model of the W=1 instance
  logic [7:0] m_key = '0, m_tkey = '0, m_bkey = '0;
  int         m_cnt = 0, m_tcnt = 0, m_bcnt = 0;
  logic       m_last = 0, m_ff = 0, m_dig = 0, m_dv = 0, m_fault = 0;
  logic [1:0] m_ks = 2'b00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic exp_busy);
    chk({tag, ".busy"}, busy, exp_busy);
    chk({tag, ".digit_valid"}, digit_valid, m_dv);
    chk({tag, ".digit"}, digit, m_dig);
    chk({tag, ".first_found"}, first_found, m_ff);
    chk({tag, ".last"}, last, m_last);
    chk({tag, ".key_cnt"}, key_cnt, m_cnt);
    chk({tag, ".key_state"}, key_state, m_ks);
    chk({tag, ".fault"}, fault, m_fault);
  endtask

  task automatic drive(input logic ld, input logic [7:0] k, input logic [1:0] op,
                       input logic fd, input logic st);
    load = ld; key_in = k; op_code = op; find_req = fd; step_req = st;
    @(posedge CLK); #1;
    load = 1'b0; op_code = 2'b00; find_req = 1'b0; step_req = 1'b0;
  endtask

  task automatic model_reset();
    m_key = '0; m_tkey = '0; m_bkey = '0; m_cnt = 0; m_tcnt = 0; m_bcnt = 0;
    m_last = 0; m_ff = 0; m_dig = 0; m_dv = 0; m_fault = 0; m_ks = 2'b00;
  endtask

  // Present one request vector; the model resolves priority and follows through.
  task automatic req(input logic ld, input logic [7:0] k, input logic [1:0] op,
                     input logic fd, input logic st, input string tag);
    int   cyc;
    int   p;
    int   exp_cyc;
    logic found;
    m_dv = 1'b0;
    if (ld) begin
      drive(ld, k, op, fd, st);
      m_key = k; m_cnt = 0; m_bkey = k; m_bcnt = 0;
      m_ff = 0; m_dig = 0; m_last = 0; m_fault = 0;
      chk_all({tag, ".load"}, 1'b1);
      drive(0, 0, 0, 0, 0);
      m_ks = (k == 8'd0) ? 2'b01 : (k == 8'd1) ? 2'b11 : 2'b00;
      chk_all({tag, ".classify"}, 1'b0);
    end else if (op != 2'b00) begin
      drive(0, 0, op, fd, st);
      if (op == 2'b01) begin
        m_tkey = m_key; m_tcnt = m_cnt;
      end else if (op == 2'b10) begin
        m_bkey = m_tkey; m_bcnt = m_tcnt;
      end else begin
        m_key = m_bkey; m_cnt = m_bcnt; m_last = (m_cnt == N);
      end
      chk_all({tag, ".op"}, 1'b0);
    end else if (fd) begin
      found = 1'b0; p = 0;
      for (int b = N - 1; b >= 0; b--) begin
        if (!found) begin
          if (m_key[b]) found = 1'b1;
          else p++;
        end
      end
      exp_cyc = found ? p + 1 : N - m_cnt;
      drive(0, 0, 0, 1, st);
      cyc = 0;
      while (busy === 1'b1 && cyc < 4 * N) begin
        chk({tag, ".find_dv_while_busy"}, digit_valid, 1'b0);
        cyc++;
        drive(0, 0, 0, 0, 0);
      end
      chk({tag, ".find_cycles"}, cyc, exp_cyc);
      if (found) begin
        m_key = m_key << (p + 1); m_cnt = m_cnt + p + 1;
        m_ff = 1; m_dig = 1; m_dv = 1;
      end else begin
        m_key = '0; m_cnt = N; m_ff = 0;
      end
      m_last = (m_cnt == N);
      chk_all({tag, ".find_done"}, 1'b0);
    end else if (st) begin
      drive(0, 0, 0, 0, 1);
      if (!m_last) begin
        m_dig = m_key[7]; m_key = m_key << 1; m_cnt++; m_dv = 1;
        m_last = (m_cnt == N);
      end
      chk_all({tag, ".step"}, 1'b0);
    end else begin
      drive(0, 0, 0, 0, 0);
      chk_all({tag, ".idle"}, 1'b0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:0] exp_bits [5];
    logic [2:0] exp_d3 [3];
    int         exp_c3 [3];
    exp_bits = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_d3   = '{3'b101, 3'b101, 3'b100};
    exp_c3   = '{3, 6, 8};

    #12;
    chk_all("reset", 1'b0);
    chk("reset.dv3", dv3, 1'b0);
    #1 RST = 1'b0;

    // Leading-one search then single-bit digits
    req(1, 8'h25, 0, 0, 0, "tp1");
    req(0, 0, 0, 1, 0, "tp1");
    chk("tp1.cnt_after_find", key_cnt, 3);
    chk("tp1.digit_after_find", digit, 1);
    for (int i = 0; i < 5; i++) begin
      req(0, 0, 0, 0, 1, "tp1");
      chk("tp1.step_digit", digit, exp_bits[i]);
    end
    chk("tp1.last", last, 1'b1);
    req(0, 0, 0, 0, 1, "tp1.exhausted");

    // W=3 windows with zero-padded final digit
    key_in3 = 8'hB6; load3 = 1'b1;
    @(posedge CLK); #1; load3 = 1'b0;
    @(posedge CLK); #1;
    chk("w3.busy_after_classify", busy3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step3 = 1'b1;
      @(posedge CLK); #1; step3 = 1'b0;
      if (i < 3) begin
        chk("w3.dv", dv3, 1'b1);
        chk("w3.digit", digit3, exp_d3[i]);
        chk("w3.cnt", cnt3, exp_c3[i]);
      end else begin
        chk("w3.dv_after_last", dv3, 1'b0);
        chk("w3.cnt_hold", cnt3, 8);
        chk("w3.last", last3, 1'b1);
      end
    end

    // Key classification and exhaustive search of a zero key
    req(1, 8'h00, 0, 0, 0, "ks0");
    chk("ks0.state", key_state, 2'b01);
    req(1, 8'h01, 0, 0, 0, "ks1");
    chk("ks1.state", key_state, 2'b11);
    req(1, 8'h00, 0, 0, 0, "zero");
    req(0, 0, 0, 1, 0, "zero");
    chk("zero.last", last, 1'b1);
    chk("zero.first_found", first_found, 1'b0);

    // Checkpoint save/commit/restore
    req(1, 8'hF0, 0, 0, 0, "ckpt");
    req(0, 0, 0, 0, 1, "ckpt");
    req(0, 0, 0, 0, 1, "ckpt");
    req(0, 0, 2'b01, 0, 0, "ckpt");
    req(0, 0, 2'b10, 0, 0, "ckpt");
    for (int i = 0; i < 3; i++) req(0, 0, 0, 0, 1, "ckpt");
    req(0, 0, 2'b11, 0, 0, "ckpt");
    chk("ckpt.cnt_restored", key_cnt, 2);
    req(0, 0, 0, 0, 1, "ckpt");
    chk("ckpt.digit_after_restore", digit, 1);

    // Priority: load beats everything, op beats find/step, find beats step
    req(1, 8'h40, 2'b01, 1, 1, "prio_load");
    req(0, 0, 2'b01, 1, 1, "prio_op");
    req(0, 0, 0, 1, 1, "prio_find");

`ifdef KEYSCAN_WIN_PARITY_EN
    req(1, 8'h5A, 0, 0, 0, "par");
    req(0, 0, 0, 0, 1, "par");
    req(0, 0, 2'b01, 0, 0, "par");
    req(0, 0, 2'b10, 0, 0, "par");
    req(0, 0, 0, 0, 1, "par");
    force dut.bak_key_q = m_bkey ^ 8'h08;
    drive(0, 0, 2'b11, 0, 0);
    release dut.bak_key_q;
    m_fault = 1'b1;
    chk_all("par.restore_aborted", 1'b0);
    chk("par.cnt_unchanged", key_cnt, 2);
    req(1, 8'h33, 0, 0, 0, "par.reload");
    chk("par.fault_cleared", fault, 1'b0);
`endif

    // Randomized request mix against the model
    for (int it = 0; it < 300; it++) begin
      logic       ld, fd, st;
      logic [1:0] op;
      logic [7:0] k;
      ld = ($urandom_range(0, 7) == 0);
      k  = 8'($urandom);
      if ($urandom_range(0, 3) == 0) k = 8'($urandom_range(0, 1));
      op = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      fd = ($urandom_range(0, 3) == 0) && (m_cnt < N);
      st = ($urandom_range(0, 1) == 1);
      req(ld, k, op, fd, st, "rnd");
    end

    // Asynchronous reset in the middle of a search
    req(1, 8'h01, 0, 0, 0, "rst");
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("rst.busy_before", busy, 1'b1);
    #2 RST = 1'b1;
    #1;
    model_reset();
    chk_all("rst.async", 1'b0);
    #3 RST = 1'b0;
    drive(0, 0, 0, 0, 0);
    chk_all("rst.after", 1'b0);
    drive(0, 0, 0, 0, 0);
    chk_all("rst.after2", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
